// File: rtl/ula_video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ula_video_pkg                                             |
// | Purpose  : Shared constants and types for the ULA video path:        |
// |            line geometry, line-buffer address width, the packed      |
// |            {i,r,g,b} pixel type and the ping-pong bank selector.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package ula_video_pkg;

   localparam int LINE_LEN = 448;  // pixels per ULA line / clk14 cycles per output line
   localparam int HSYNC_W  = 54;   // output hsync width in clk14 cycles
   localparam int AW       = 9;    // line-buffer address width, 2**AW >= LINE_LEN

   typedef struct packed {
      logic i;
      logic r;
      logic g;
      logic b;
   } rgbi_t;

   typedef enum logic {
      BANK_A = 1'b0,
      BANK_B = 1'b1
   } bank_t;

   function automatic bank_t other_bank(input bank_t b);
      return (b == BANK_A) ? BANK_B : BANK_A;
   endfunction

endpackage
`default_nettype wire

// File: rtl/scandbl_linebuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : scandbl_linebuf                                           |
// | Purpose  : Simple dual-port line buffer holding two ULA lines (one   |
// |            bank per line). One write port, one registered read port, |
// |            no reset so it maps onto block RAM.                       |
// | Ports    : clk14        - clock                                      |
// |            we/waddr/wdata - write port, MSB of address is the bank   |
// |            raddr/rdata  - read port, rdata valid one cycle later     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module scandbl_linebuf
   import ula_video_pkg::*;
#(
   parameter int ADDR_W = AW + 1
)(
   input  logic              clk14,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  rgbi_t             wdata,
   input  logic [ADDR_W-1:0] raddr,
   output rgbi_t             rdata
);

   rgbi_t r_mem [0:(2**ADDR_W)-1];

   always_ff @(posedge clk14) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
      rdata <= r_mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/ula_scandoubler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ula_scandoubler                                           |
// | Purpose  : Captures each 15.6 kHz ULA line into a ping-pong buffer   |
// |            and replays it twice at clk14, giving 31 kHz RGBI.        |
// |            Bypass mode registers the 15 kHz signals straight out.    |
// | Ports    : clk14, rst_n (async, active low), pix_ce (clk7 enable),   |
// |            scandbl_en (1 = doubled), r/g/b/i_in, hsync_n_in,         |
// |            vsync_n_in; r/g/b/i_o, hsync_n_o, vsync_n_o, line_odd_o.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ula_scandoubler
   import ula_video_pkg::*;
(
   input  logic clk14,
   input  logic rst_n,
   input  logic pix_ce,
   input  logic scandbl_en,
   input  logic r_in,
   input  logic g_in,
   input  logic b_in,
   input  logic i_in,
   input  logic hsync_n_in,
   input  logic vsync_n_in,
   output logic r_o,
   output logic g_o,
   output logic b_o,
   output logic i_o,
   output logic hsync_n_o,
   output logic vsync_n_o,
   output logic line_odd_o
);

   localparam logic [AW:0]   c_wr_end  = (AW+1)'(LINE_LEN);
   localparam logic [AW:0]   c_wr_one  = (AW+1)'(1);
   localparam logic [AW-1:0] c_rd_last = AW'(LINE_LEN - 1);
   localparam logic [AW-1:0] c_rd_one  = AW'(1);
   localparam logic [AW-1:0] c_hs_w    = AW'(HSYNC_W);

   logic          r_hs_prev;
   logic          w_ls;
   logic [AW:0]   r_wr_x;      // one bit wider so it can saturate at LINE_LEN
   bank_t         r_wbank;
   bank_t         r_rbank;
   logic [AW-1:0] r_rd_x;
   logic          r_line_odd;
   logic          r_mode;
   logic          r_run;       // set by the first line start after reset

   // first pipeline stage, aligned with the RAM read register
   logic [AW-1:0] r_rd_x_d1;
   logic          r_odd_d1;
   logic          r_run_d1;
   logic          r_vs_line;

   logic          w_we;
   logic [AW:0]   w_waddr;
   logic [AW:0]   w_raddr;
   rgbi_t         w_wdata;
   rgbi_t         w_rdata;

   always_comb begin
      w_ls    = pix_ce & r_hs_prev & ~hsync_n_in;
      w_wdata = '{i: i_in, r: r_in, g: g_in, b: b_in};
      w_we    = 1'b0;
      w_waddr = {r_wbank, r_wr_x[AW-1:0]};
      if (w_ls) begin
         // the bank toggle wins: the line-start pixel opens the new bank
         w_we    = 1'b1;
         w_waddr = {other_bank(r_wbank), {AW{1'b0}}};
      end else if (pix_ce && (r_wr_x < c_wr_end)) begin
         w_we    = 1'b1;
      end
      w_raddr = {r_rbank, r_rd_x};
   end

   scandbl_linebuf #(
      .ADDR_W (AW + 1)
   ) u_linebuf (
      .clk14  (clk14),
      .we     (w_we),
      .waddr  (w_waddr),
      .wdata  (w_wdata),
      .raddr  (w_raddr),
      .rdata  (w_rdata)
   );

   // write side: capture one ULA line per bank
   always_ff @(posedge clk14 or negedge rst_n) begin
      if (!rst_n) begin
         r_hs_prev <= 1'b1;
         r_wr_x    <= '0;
         r_wbank   <= BANK_A;
      end else if (pix_ce) begin
         r_hs_prev <= hsync_n_in;
         if (w_ls) begin
            r_wr_x  <= c_wr_one;
            r_wbank <= other_bank(r_wbank);
         end else if (r_wr_x < c_wr_end) begin
            r_wr_x  <= r_wr_x + c_wr_one;
         end
      end
   end

   // read side: free-running replay, resynchronised by every line start
   always_ff @(posedge clk14 or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_x     <= '0;
         r_rbank    <= BANK_A;
         r_line_odd <= 1'b0;
         r_mode     <= 1'b1;
         r_run      <= 1'b0;
      end else begin
         if (w_ls) begin
            r_rd_x     <= '0;
            r_rbank    <= r_wbank;   // the bank that just closed
            r_line_odd <= 1'b0;
            r_run      <= 1'b1;
         end else if (r_rd_x == c_rd_last) begin
            r_rd_x     <= '0;
            r_line_odd <= ~r_line_odd;
         end else begin
            r_rd_x     <= r_rd_x + c_rd_one;
         end
         // mode only changes at an output line boundary
         if (r_rd_x == '0) begin
            r_mode <= scandbl_en;
         end
      end
   end

   always_ff @(posedge clk14 or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_x_d1 <= '0;
         r_odd_d1  <= 1'b0;
         r_run_d1  <= 1'b0;
         r_vs_line <= 1'b1;
      end else begin
         r_rd_x_d1 <= r_rd_x;
         r_odd_d1  <= r_line_odd;
         r_run_d1  <= r_run;
         if (r_rd_x == '0) begin
            r_vs_line <= vsync_n_in;
         end
      end
   end

   // output register; until the first line start the doubled output stays
   // at idle levels so a syncless input produces a quiet screen
   always_ff @(posedge clk14 or negedge rst_n) begin
      if (!rst_n) begin
         {i_o, r_o, g_o, b_o} <= 4'b0000;
         hsync_n_o            <= 1'b1;
         vsync_n_o            <= 1'b1;
         line_odd_o           <= 1'b0;
      end else if (r_mode) begin
         if (r_run_d1) begin
            {i_o, r_o, g_o, b_o} <= w_rdata;
            hsync_n_o            <= (r_rd_x_d1 >= c_hs_w);
            vsync_n_o            <= r_vs_line;
            line_odd_o           <= r_odd_d1;
         end else begin
            {i_o, r_o, g_o, b_o} <= 4'b0000;
            hsync_n_o            <= 1'b1;
            vsync_n_o            <= 1'b1;
            line_odd_o           <= 1'b0;
         end
      end else if (pix_ce) begin
         {i_o, r_o, g_o, b_o} <= {i_in, r_in, g_in, b_in};
         hsync_n_o            <= hsync_n_in;
         vsync_n_o            <= vsync_n_in;
         line_odd_o           <= 1'b0;
      end
   end

endmodule
`default_nettype wire
